// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN, one full-subtractor cell per clock, LSB first.
// Define SUB_SATURATE_EN to clamp an underflowed result to zero (borrow-out still reported).
module tt_um_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ui_a,
  input  logic [WIDTH-1:0] ui_b,
  input  logic             ui_bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] uo_diff,
  output logic             uo_bout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             d_bit;
  logic             br_nxt;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = ui_a;
          b_d     = ui_b;
          br_d    = ui_bin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        // result bits enter at the top and walk down toward bit 0
        res_d = (WIDTH-1)'({d_bit, res_q} >> 1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          bout_d  = br_nxt;
`ifdef SUB_SATURATE_EN
          diff_d  = br_nxt ? '0 : {d_bit, res_q};
`else
          diff_d  = {d_bit, res_q};
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign uo_diff   = diff_q;
  assign uo_bout   = bout_q;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Self-checking bench for tt_um_serial_subtractor (WIDTH=8).
// Honours SUB_SATURATE_EN in its expectations when the macro is defined.
module tb_tt_um_serial_subtractor;

  localparam int W = 8;
  localparam int NRAND = 1000;
`ifdef SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] ui_a = '0;
  logic [W-1:0] ui_b = '0;
  logic         ui_bin = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] uo_diff;
  logic         uo_bout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;

  int total = 0;
  int bad = 0;

  tt_um_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .ui_a(ui_a),
    .ui_b(ui_b),
    .ui_bin(ui_bin),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .uo_diff(uo_diff),
    .uo_bout(uo_bout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: plain integer subtraction, then the optional floor
  function automatic logic [W:0] model(input int a, input int b,
                                       input int bin);
    int r;
    logic [W:0] res;
    r = a - b - bin;
    res = (W+1)'(r & ((1 << (W+1)) - 1));
    if (SAT && res[W]) res[W-1:0] = '0;
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, output logic [W-1:0] d,
                       output logic bo, output int lat);
    int n;
    ui_a = a;
    ui_b = b;
    ui_bin = bin;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    d = uo_diff;
    bo = uo_bout;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  vec_t vecs[8];
  logic [W-1:0] gd;
  logic gb;
  int lat;
  logic seen;

  logic [W:0] expq[$];
  int accepted;
  int received;
  bit drv_done;

  initial begin
    vecs[0] = '{8'd200, 8'd55,  1'b0, 8'd145, 1'b0};
    vecs[1] = '{8'd10,  8'd20,  1'b0, 8'd246, 1'b1};
    vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
    vecs[3] = '{8'd255, 8'd255, 1'b0, 8'd0,   1'b0};
    vecs[4] = '{8'd1,   8'd1,   1'b0, 8'd0,   1'b0};
    vecs[5] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1};
    vecs[6] = '{8'd255, 8'd0,   1'b1, 8'd254, 1'b0};
    vecs[7] = '{8'd128, 8'd127, 1'b1, 8'd0,   1'b0};

    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_diff", uo_diff, 0);
    chk("rst_bout", uo_bout, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, gd, gb, lat);
      chk($sformatf("vec%0d_lat", i), lat, W);
      chk($sformatf("vec%0d_diff", i), gd,
          (SAT && vecs[i].bout) ? 0 : vecs[i].diff);
      chk($sformatf("vec%0d_bout", i), gb, vecs[i].bout);
      take();
      chk($sformatf("vec%0d_idle", i), in_ready, 1);
    end

    // backpressure: result held, new operands ignored
    do_op(8'd50, 8'd8, 1'b1, gd, gb, lat);
    chk("bp_diff0", gd, 41);
    for (int i = 0; i < 5; i++) begin
      ui_a = 8'd99;
      ui_b = 8'd1;
      in_valid = 1'b1;
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_diff", uo_diff, 41);
    end
    in_valid = 1'b0;
    take();
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_ready", in_ready, 1);
    chk("bp_rel_busy", busy, 0);
    chk("bp_hold_diff", uo_diff, 41);

    // out_ready without a result has no effect
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("idle_ready_busy", busy, 0);
    chk("idle_ready_diff", uo_diff, 41);

    // same-edge result handshake and new operands
    do_op(8'd7, 8'd3, 1'b0, gd, gb, lat);
    chk("se_diff0", gd, 4);
    ui_a = 8'd100;
    ui_b = 8'd1;
    ui_bin = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("se_valid", out_valid, 0);
    chk("se_busy", busy, 0);
    chk("se_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("se_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("se_lat", lat, W);
    chk("se_diff", uo_diff, 99);
    take();

    // reset in the middle of SHIFT
    ui_a = 8'd200;
    ui_b = 8'd55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_diff", uo_diff, 0);
    chk("mid_rst_bout", uo_bout, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_pulse", seen, 0);
    do_op(8'd1, 8'd1, 1'b0, gd, gb, lat);
    chk("post_rst_lat", lat, W);
    chk("post_rst_diff", gd, 0);
    chk("post_rst_bout", gb, 0);
    take();

    // random sweep with stalls on both sides
    accepted = 0;
    received = 0;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          int n;
          bit acc;
          int stall;
          stall = $urandom_range(0, 3);
          for (int s = 0; s < stall; s++) tick();
          ui_a = W'($urandom);
          ui_b = W'($urandom);
          ui_bin = 1'($urandom);
          in_valid = 1'b1;
          n = 0;
          do begin
            acc = in_ready;
            tick();
            n++;
          end while (!acc && n < 200);
          if (!acc) begin
            chk("rand_accept_timeout", 0, 1);
            break;
          end
          expq.push_back(model(int'(ui_a), int'(ui_b), int'(ui_bin)));
          accepted++;
          in_valid = 1'b0;
        end
        in_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        logic [W:0] e;
        int cyc;
        cyc = 0;
        while (received < NRAND && cyc < 60000) begin
          out_ready = 1'($urandom);
          if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
              chk("rand_extra_result", 0, 1);
            end else begin
              e = expq.pop_front();
              chk("rand_result", {uo_bout, uo_diff}, e);
            end
            received++;
          end
          tick();
          cyc++;
          if (drv_done && expq.size() == 0 && !busy) break;
        end
        out_ready = 1'b0;
      end
    join
    chk("rand_accepted", accepted, NRAND);
    chk("rand_received", received, NRAND);
    chk("rand_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
